// File: rtl/irq_ctrl.sv
// irq_ctrl: edge-triggered interrupt controller with per-source pending/overflow tracking
// and a single-level IDLE/SERVICE delivery FSM. Define IRQ_ROUND_ROBIN_EN for rotating arbitration.
module irq_ctrl #(
    parameter int unsigned NUM_SRC = 4,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ID_W    = $clog2(NUM_SRC)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_SRC-1:0]        irq_req,
    input  logic [NUM_SRC*DATA_W-1:0] irq_src_data,
    input  logic [NUM_SRC-1:0]        irq_mask,
    input  logic                      stall_irq,
    input  logic                      irq_return,
    output logic                      irq_take,
    output logic [ID_W-1:0]           irq_id,
    output logic [DATA_W-1:0]         irq_rdata,
    output logic                      irq_active,
    output logic [NUM_SRC-1:0]        irq_pending,
    output logic [NUM_SRC-1:0]        irq_ovf
);

    typedef enum logic {
        IDLE    = 1'b0,
        SERVICE = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [NUM_SRC-1:0]  req_q, req_d;
    logic                armed_q, armed_d;
    logic [NUM_SRC-1:0]  pend_q, pend_d;
    logic [NUM_SRC-1:0]  ovf_q, ovf_d;
    logic [DATA_W-1:0]   buf_q [NUM_SRC];
    logic [DATA_W-1:0]   buf_d [NUM_SRC];
    logic                take_q, take_d;
    logic                active_q, active_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;

    logic [NUM_SRC-1:0]  elig;
    logic [ID_W-1:0]     grant_id;
    logic [NUM_SRC-1:0]  grant_oh;
    logic                deliver;
    logic [NUM_SRC-1:0]  rise;
    logic [NUM_SRC-1:0]  clr;
    logic [NUM_SRC-1:0]  keep;

    function automatic logic [ID_W-1:0] lowest_idx(input logic [NUM_SRC-1:0] v);
        logic [ID_W-1:0] idx;
        idx = '0;
        for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = ID_W'(i);
            end
        end
        return idx;
    endfunction

`ifdef IRQ_ROUND_ROBIN_EN
    logic [ID_W-1:0]     ptr_q, ptr_d;
    logic [NUM_SRC-1:0]  ge_ptr;

    // Rotating search: prefer eligible sources at or above the pointer, else wrap to the lowest.
    always_comb begin
        ge_ptr = '0;
        for (int i = 0; i < int'(NUM_SRC); i++) begin
            ge_ptr[i] = (ID_W'(i) >= ptr_q);
        end
        if (|(elig & ge_ptr)) begin
            grant_id = lowest_idx(elig & ge_ptr);
        end else begin
            grant_id = lowest_idx(elig);
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (deliver) begin
            if (grant_id == ID_W'(NUM_SRC - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = grant_id + ID_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    always_comb begin
        grant_id = lowest_idx(elig);
    end
`endif

    assign elig     = pend_q & irq_mask;
    assign deliver  = (state_q == IDLE) && (|elig) && !stall_irq;
    assign grant_oh = NUM_SRC'(1) << grant_id;

    // Edge detection is suppressed for the first cycle after reset so a held-high source is not seen as rising.
    always_comb begin
        armed_d = 1'b1;
        req_d   = irq_req;
        rise    = irq_req & ~req_q & {NUM_SRC{armed_q}};
    end

    // Pending/overflow/buffer update; a fresh edge on the source being delivered re-arms it (set wins).
    always_comb begin
        clr    = deliver ? grant_oh : '0;
        keep   = pend_q & ~clr;
        pend_d = keep | rise;
        ovf_d  = ovf_q | (rise & keep);
        buf_d  = buf_q;
        for (int i = 0; i < int'(NUM_SRC); i++) begin
            if (rise[i] && !keep[i]) begin
                buf_d[i] = irq_src_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Delivery FSM: next state and registered outputs.
    always_comb begin
        state_d = state_q;
        take_d  = 1'b0;
        id_d    = id_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (deliver) begin
                    take_d  = 1'b1;
                    id_d    = grant_id;
                    rdata_d = buf_q[grant_id];
                    state_d = SERVICE;
                end
            end
            SERVICE: begin
                if (irq_return) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        active_d = (state_d == SERVICE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            req_q    <= '0;
            armed_q  <= 1'b0;
            pend_q   <= '0;
            ovf_q    <= '0;
            take_q   <= 1'b0;
            active_q <= 1'b0;
            id_q     <= '0;
            rdata_q  <= '0;
            for (int i = 0; i < int'(NUM_SRC); i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            armed_q  <= armed_d;
            pend_q   <= pend_d;
            ovf_q    <= ovf_d;
            take_q   <= take_d;
            active_q <= active_d;
            id_q     <= id_d;
            rdata_q  <= rdata_d;
            for (int i = 0; i < int'(NUM_SRC); i++) begin
                buf_q[i] <= buf_d[i];
            end
        end
    end

    assign irq_take    = take_q;
    assign irq_id      = id_q;
    assign irq_rdata   = rdata_q;
    assign irq_active  = active_q;
    assign irq_pending = pend_q;
    assign irq_ovf     = ovf_q;

endmodule
